// File: rtl/layer_seq_pkg.sv
// Shared types and defaults for the layer sequencer.
// Optional build macro: LAYER_SEQ_BIAS_EN adds one bias slot in front of
// every neuron (weight read from the bias region, input address held).
package layer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_N_IN  = 4;
  localparam int DEF_N_OUT = 3;
  localparam int DEF_AW    = 16;

`ifdef LAYER_SEQ_BIAS_EN
  localparam int BIAS_SLOTS = 1;
`else
  localparam int BIAS_SLOTS = 0;
`endif

  // Address slots issued per neuron (inputs plus optional bias slot).
  function automatic int slots_per_neuron(input int n_in);
    return n_in + BIAS_SLOTS;
  endfunction

endpackage

// File: rtl/layer_seq_cnt.sv
// Nested slot/neuron counter: k runs fastest over 0..K_N-1, j over 0..J_N-1.
// Terminal flags let the sequencer see the last slot of a neuron and the
// last neuron of the layer without extra comparators.
module layer_seq_cnt #(
  parameter int K_N = 4,
  parameter int J_N = 3,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] k_o,
  output logic [W-1:0] j_o,
  output logic         k_last_o,
  output logic         j_last_o
);

  logic [W-1:0] k_q, k_d;
  logic [W-1:0] j_q, j_d;

  assign k_o      = k_q;
  assign j_o      = j_q;
  assign k_last_o = (k_q == W'(K_N - 1));
  assign j_last_o = (j_q == W'(J_N - 1));

  // Next count: clear wins, otherwise k wraps into a j increment.
  always_comb begin
    k_d = k_q;
    j_d = j_q;
    if (clr_i) begin
      k_d = '0;
      j_d = '0;
    end else if (en_i) begin
      if (k_last_o) begin
        k_d = '0;
        j_d = j_last_o ? '0 : j_q + W'(1);
      end else begin
        k_d = k_q + W'(1);
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
      j_q <= '0;
    end else begin
      k_q <= k_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer for a multiply-accumulate neuron datapath.
// One pass issues an (input, weight) address pair per cycle for every
// neuron, then drives the accumulator one cycle later (1-cycle memory
// latency) and strobes the result write the cycle after each neuron's
// last accumulate. Optional build macro: LAYER_SEQ_BIAS_EN.
//
// Handshake: start is sampled only in IDLE; busy covers the whole pass
// including the pipeline flush; done is a single-cycle pulse with busy low.
// dbg_state_o exposes the FSM state for checkers.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] in_addr,
  output logic [AW-1:0] w_addr,
  output logic          acc_sel,
  output logic          acc_en,
  output logic [AW-1:0] out_idx,
  output logic          out_we,
  output logic [1:0]    dbg_state_o
);

  localparam int SLOTS = slots_per_neuron(N_IN);

  state_e state_q, state_d;

  logic          cnt_clr, cnt_en;
  logic [AW-1:0] k_cur, j_cur;
  logic          k_last, j_last;
  logic          run;

  // Issue stage: addresses presented to the memories.
  logic [AW-1:0] in_addr_q, in_addr_d;
  logic [AW-1:0] w_addr_q,  w_addr_d;
`ifdef LAYER_SEQ_BIAS_EN
  // Next data-weight address; bias slots borrow w_addr from the bias region.
  logic [AW-1:0] wd_q, wd_d;
`endif

  // Accumulate stage: one cycle behind the issue stage.
  logic          acc_en_q,   acc_en_d;
  logic          acc_sel_q,  acc_sel_d;
  logic          s1_last_q,  s1_last_d;
  logic          s1_final_q, s1_final_d;
  logic [AW-1:0] s1_j_q,     s1_j_d;

  // Write stage: one cycle behind the accumulate stage.
  logic          out_we_q,    out_we_d;
  logic          out_final_q, out_final_d;
  logic [AW-1:0] out_idx_q,   out_idx_d;

  layer_seq_cnt #(
    .K_N (SLOTS),
    .J_N (N_OUT),
    .W   (AW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .k_o      (k_cur),
    .j_o      (j_cur),
    .k_last_o (k_last),
    .j_last_o (j_last)
  );

  assign run         = (state_q == RUN);
  assign busy        = (state_q == RUN) || (state_q == FLUSH);
  assign done        = (state_q == DONE);
  assign in_addr     = in_addr_q;
  assign w_addr      = w_addr_q;
  assign acc_en      = acc_en_q;
  assign acc_sel     = acc_sel_q;
  assign out_we      = out_we_q;
  assign out_idx     = out_idx_q;
  assign dbg_state_o = state_q;

  // FSM next state and counter control.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (k_last && j_last) state_d = FLUSH;
        else                  cnt_en  = 1'b1;
      end
      FLUSH: begin
        if (out_we_q && out_final_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address generation: the registers always hold the slot the counter is on.
  always_comb begin
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
`ifdef LAYER_SEQ_BIAS_EN
    wd_d = wd_q;
    if (cnt_clr) begin
      w_addr_d = AW'(N_IN * N_OUT);
      wd_d     = '0;
    end else if (cnt_en) begin
      if (k_last) begin
        w_addr_d = AW'(N_IN * N_OUT) + j_cur + AW'(1);
      end else begin
        in_addr_d = (k_cur == '0) ? '0 : in_addr_q + AW'(1);
        w_addr_d  = wd_q;
        wd_d      = wd_q + AW'(1);
      end
    end
`else
    if (cnt_clr) begin
      in_addr_d = '0;
      w_addr_d  = '0;
    end else if (cnt_en) begin
      in_addr_d = k_last ? '0 : in_addr_q + AW'(1);
      w_addr_d  = w_addr_q + AW'(1);
    end
`endif
  end

  // Pipeline controls: accumulate follows issue, write follows the last accumulate.
  always_comb begin
    acc_en_d    = run;
    acc_sel_d   = run && (k_cur != '0);
    s1_last_d   = run && k_last;
    s1_final_d  = run && k_last && j_last;
    s1_j_d      = run ? j_cur : s1_j_q;
    out_we_d    = acc_en_q && s1_last_q;
    out_final_d = acc_en_q && s1_final_q;
    out_idx_d   = (acc_en_q && s1_last_q) ? s1_j_q : out_idx_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; reset also discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_addr_q   <= '0;
      w_addr_q    <= '0;
      acc_en_q    <= 1'b0;
      acc_sel_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_final_q  <= 1'b0;
      s1_j_q      <= '0;
      out_we_q    <= 1'b0;
      out_final_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      in_addr_q   <= in_addr_d;
      w_addr_q    <= w_addr_d;
      acc_en_q    <= acc_en_d;
      acc_sel_q   <= acc_sel_d;
      s1_last_q   <= s1_last_d;
      s1_final_q  <= s1_final_d;
      s1_j_q      <= s1_j_d;
      out_we_q    <= out_we_d;
      out_final_q <= out_final_d;
      out_idx_q   <= out_idx_d;
    end
  end

`ifdef LAYER_SEQ_BIAS_EN
  // Data-weight counter used only when bias slots are interleaved.
  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Testbench for layer_sequencer (honours LAYER_SEQ_BIAS_EN when defined).
// Expected per-cycle events are pushed into exp_q when a pass is launched;
// a negedge monitor turns DUT activity into events and compares in order.
module tb_layer_sequencer;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int AW    = 16;
`ifdef LAYER_SEQ_BIAS_EN
  localparam int BIAS = 1;
`else
  localparam int BIAS = 0;
`endif
  localparam int P  = N_IN + BIAS;
  localparam int NS = N_OUT * P;
  localparam int W  = 64;

  localparam logic [7:0] K_BUSY = 8'd1;
  localparam logic [7:0] K_ADDR = 8'd2;
  localparam logic [7:0] K_ACC  = 8'd3;
  localparam logic [7:0] K_WE   = 8'd4;
  localparam logic [7:0] K_DONE = 8'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;

  logic          busy, done, acc_sel, acc_en, out_we;
  logic [AW-1:0] in_addr, w_addr, out_idx;
  logic [1:0]    dbg_state;

  logic          busy1, done1, acc_sel1, acc_en1, out_we1;
  logic [AW-1:0] in_addr1, w_addr1, out_idx1;
  logic [1:0]    dbg_state1;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int base;
  logic [W-1:0] exp_q[$];

  layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .w_addr(w_addr), .acc_sel(acc_sel), .acc_en(acc_en),
    .out_idx(out_idx), .out_we(out_we), .dbg_state_o(dbg_state)
  );

  layer_sequencer #(.N_IN(N_IN), .N_OUT(1), .AW(AW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .in_addr(in_addr1), .w_addr(w_addr1), .acc_sel(acc_sel1), .acc_en(acc_en1),
    .out_idx(out_idx1), .out_we(out_we1), .dbg_state_o(dbg_state1)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ev(input int c, input logic [7:0] kind, input logic [23:0] data);
    return {c[31:0], kind, data};
  endfunction

  task automatic observe(input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got %0h expected none", act);
    end else begin
      e = exp_q.pop_front();
      check("event", act, e);
    end
  endtask

  // Monitor: one event per active output class per cycle, fixed order.
  always @(negedge clk) begin
    if (busy)               observe(ev(cyc, K_BUSY, 24'd0));
    if (dbg_state == 2'd1)  observe(ev(cyc, K_ADDR, {in_addr[7:0], w_addr}));
    if (acc_en || acc_sel)  observe(ev(cyc, K_ACC, {22'd0, acc_en, acc_sel}));
    if (out_we)             observe(ev(cyc, K_WE, {8'd0, out_idx}));
    if (done)               observe(ev(cyc, K_DONE, 24'd0));
  end

  // Expected trace of one pass launched with cycle 1 at absolute base+1.
  task automatic push_trace(input int b, input int upto, input int prev_in);
    int s, j, ia, wa, sel;
    for (int c = 1; c <= NS + 3 && c <= upto; c++) begin
      if (c <= NS + 2) exp_q.push_back(ev(b + c, K_BUSY, 24'd0));
      if (c <= NS) begin
        s = (c - 1) % P;
        j = (c - 1) / P;
        if (BIAS == 1 && s == 0) begin
          ia = (j == 0) ? prev_in : N_IN - 1;
          wa = N_IN * N_OUT + j;
        end else begin
          ia = s - BIAS;
          wa = j * N_IN + s - BIAS;
        end
        exp_q.push_back(ev(b + c, K_ADDR, {ia[7:0], wa[15:0]}));
      end
      if (c >= 2 && c <= NS + 1) begin
        sel = (((c - 2) % P) != 0) ? 1 : 0;
        exp_q.push_back(ev(b + c, K_ACC, {22'd0, 1'b1, sel[0]}));
      end
      if (c >= 3 && c <= NS + 2 && ((c - 2) % P) == 0) begin
        j = (c - 2) / P - 1;
        exp_q.push_back(ev(b + c, K_WE, {8'd0, j[15:0]}));
      end
      if (c == NS + 3) exp_q.push_back(ev(b + c, K_DONE, 24'd0));
    end
  endtask

  task automatic to_neg(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    busy,      '0);
    check({tag, "_done"},    done,      '0);
    check({tag, "_acc_en"},  acc_en,    '0);
    check({tag, "_acc_sel"}, acc_sel,   '0);
    check({tag, "_out_we"},  out_we,    '0);
    check({tag, "_in_addr"}, in_addr,   '0);
    check({tag, "_w_addr"},  w_addr,    '0);
    check({tag, "_out_idx"}, out_idx,   '0);
    check({tag, "_state"},   dbg_state, '0);
  endtask

  // Launch a pass: start sampled at the next edge; base is cycle 0 of it.
  task automatic launch(input int prev_in);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    base = cyc - 1;
    push_trace(base, 1000, prev_in);
  endtask

  int we_cnt, we_c, we_idx, done_c;

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Single pass with a stray start pulse in cycle 5 (must be ignored).
    launch(0);
    @(negedge clk);
    start = 1'b0;
    to_neg(base + 5);
    start = 1'b1;
    to_neg(base + 6);
    start = 1'b0;
    to_neg(base + NS + 6);

    // Start held high: second pass follows the IDLE cycle after done.
    launch(N_IN - 1);
    repeat (NS + 4) @(posedge clk);
    #1;
    base = cyc - 1;
    push_trace(base, 1000, N_IN - 1);
    @(negedge clk);
    start = 1'b0;
    to_neg(base + NS + 6);

    // Reset in cycle 7 of a pass: everything clears, nothing trails.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    base = cyc - 1;
    push_trace(base, 7, N_IN - 1);
    @(negedge clk);
    start = 1'b0;
    to_neg(base + 7);
    rst = 1'b1;
    to_neg(base + 8);
    check_idle("midrst");
    rst = 1'b0;
    to_neg(base + 12);

    // Fresh pass after the mid-pass reset.
    launch(0);
    @(negedge clk);
    start = 1'b0;
    to_neg(base + NS + 6);

    // Single-neuron layer: one write strobe then done.
    we_cnt = 0;
    we_c = 0;
    we_idx = -1;
    done_c = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int c = 1; c <= P + 6; c++) begin
      @(negedge clk);
      if (out_we1) begin
        we_cnt++;
        we_c = c;
        we_idx = int'(out_idx1);
      end
      if (done1) done_c = c;
    end
    check("n1_we_count", we_cnt, 1);
    check("n1_we_cycle", we_c, P + 2);
    check("n1_we_idx",   we_idx, 0);
    check("n1_done_cyc", done_c, P + 3);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning inputs per neuron (>=2).
REQ-002 SHALL have parameter N_OUT, default 3, meaning neurons per layer (>=1).
REQ-003 SHALL have parameter AW, default 16, meaning width of all address outputs.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request to run one layer pass.
REQ-007 SHALL have port busy, output, 1, pass in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse at pass end.
REQ-009 SHALL have port in_addr, output, AW, input-vector RAM read address.
REQ-010 SHALL have port w_addr, output, AW, weight ROM read address.
REQ-011 SHALL have port acc_sel, output, 1, accumulator mux: 0 = load product, 1 = add product.
REQ-012 SHALL have port acc_en, output, 1, accumulator register enable.
REQ-013 SHALL have port out_idx, output, AW, neuron index for result write.
REQ-014 SHALL have port out_we, output, 1, result write strobe; accumulator output valid this cycle.

Function
REQ-015 SHALL run states IDLE -> RUN -> FLUSH -> DONE -> IDLE.
REQ-016 In IDLE, SHALL sample start=1 on edge E0 and enter RUN; cycle c means the cycle after edge Ec.
REQ-017 In RUN, SHALL issue one address pair per cycle, cycles 1..N_IN*N_OUT, with neuron j in 0..N_OUT-1 and input k in 0..N_IN-1, k fastest.
REQ-018 SHALL drive in_addr=k and w_addr=j*N_IN+k; w_addr SHALL come from an incrementing counter, not a multiplier.
REQ-019 SHALL assert acc_en exactly one cycle after each address issue, for 1-cycle memory read latency; acc_en is therefore high for cycles 2..N_IN*N_OUT+1.
REQ-020 SHALL drive acc_sel=0 with the acc_en for k=0 and acc_sel=1 otherwise.
REQ-021 Neurons SHALL run back-to-back with no bubble; the k=0 load of neuron j+1 overwrites the sum of neuron j.
REQ-022 SHALL pulse out_we with out_idx=j at cycle (j+1)*N_IN+2, the cycle after neuron j's last acc_en.
REQ-023 After the last address issue, SHALL enter FLUSH; leave FLUSH after the final out_we; DONE lasts one cycle.
REQ-024 done SHALL pulse at cycle N_IN*N_OUT+3; busy SHALL be high for cycles 1..N_IN*N_OUT+2 and low during the done pulse.
REQ-025 start while busy or in DONE SHALL be ignored; start held high SHALL restart on the edge after DONE (IDLE sampling).
REQ-026 k SHALL wrap N_IN-1 -> 0 while incrementing j; after j=N_OUT-1, k=N_IN-1, no further address issue.
REQ-027 When no acc_en/out_we is due, acc_en, out_we and acc_sel SHALL be 0; addresses hold their last value.

Reset
REQ-028 rst=1 at any edge, including mid-pass, SHALL force IDLE, with busy=done=acc_en=out_we=acc_sel=0 and in_addr=w_addr=out_idx=0.
REQ-029 Reset SHALL discard any pending acc_en or out_we; no pulse SHALL appear after the reset edge.
REQ-030 rst SHALL take priority over start on the same edge.

Configuration
REQ-031 Macro LAYER_SEQ_BIAS_EN compiled in SHALL prefix each neuron with a bias slot.
REQ-032 With LAYER_SEQ_BIAS_EN, the bias slot SHALL issue w_addr = N_IN*N_OUT + j and hold in_addr, giving acc_sel=0 on its acc_en; all N_IN inputs SHALL then use acc_sel=1.
REQ-033 With LAYER_SEQ_BIAS_EN, every timing formula SHALL use N_IN+1 in place of N_IN.
REQ-034 Without LAYER_SEQ_BIAS_EN, behaviour SHALL be exactly REQ-017..REQ-027.

Structure
REQ-035 Package layer_seq_pkg SHALL hold the state enum (IDLE, RUN, FLUSH, DONE) and default N_IN/N_OUT/AW constants.
REQ-036 A sub-module layer_seq_cnt, a nested k/j wrap counter with terminal flags, SHALL be instantiated once.

Verification
REQ-037 Single pass, N_IN=4, N_OUT=3, start at E0 -> acc_en cycles 2..13; acc_sel=0 at cycles 2, 6, 10; out_we at cycles 6, 10, 14 with out_idx 0, 1, 2; done at 15.
REQ-038 w_addr sequence check, same parameters -> w_addr = 0..11 on cycles 1..12; in_addr = 0,1,2,3 repeated.
REQ-039 start pulsed at cycle 5 mid-pass -> trace identical to REQ-037; start held high -> second pass begins at the edge after done.
REQ-040 rst=1 at cycle 7 -> from cycle 8 all outputs are 0 and state is IDLE; a new start then yields the REQ-037 trace.
REQ-041 LAYER_SEQ_BIAS_EN defined, N_IN=4, N_OUT=3 -> w_addr=12 at cycle 1 then 0..3; out_we at cycles 7, 12, 17; done at 18.
REQ-042 N_OUT=1 boundary -> exactly one out_we (cycle 6, out_idx 0) followed by done at cycle 7.
